// File: rtl/filter_input_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream filter input between
// NUM_INPUTS upstream ports. Each input lands in a small fallthrough FIFO; one input
// is granted per packet and its beats are forwarded verbatim.
module filter_input_arbiter #(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned NUM_INPUTS           = 4,
  parameter int unsigned FIFO_DEPTH_BITS      = 2
) (
  input  logic                                          axi_aclk,
  input  logic                                          axi_aresetn,
  input  logic [NUM_INPUTS*C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_INPUTS*C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic [NUM_INPUTS*C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic [NUM_INPUTS-1:0]                         s_axis_tvalid,
  output logic [NUM_INPUTS-1:0]                         s_axis_tready,
  input  logic [NUM_INPUTS-1:0]                         s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic                                          m_axis_tvalid,
  input  logic                                          m_axis_tready,
  output logic                                          m_axis_tlast,
  output logic [$clog2(NUM_INPUTS)-1:0]                 grant_idx,
  output logic [31:0]                                   pkt_count
);

  localparam int unsigned IdxW  = $clog2(NUM_INPUTS);
  localparam int unsigned PtrW  = FIFO_DEPTH_BITS;
  localparam int unsigned CntW  = FIFO_DEPTH_BITS + 1;
  localparam int unsigned Depth = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned DataW = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned StrbW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UserW = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned BeatW = DataW + StrbW + UserW + 1;

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  logic [BeatW-1:0]      mem_q    [NUM_INPUTS][Depth];
  logic [PtrW-1:0]       wr_ptr_q [NUM_INPUTS];
  logic [PtrW-1:0]       rd_ptr_q [NUM_INPUTS];
  logic [CntW-1:0]       count_q  [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] wr_en, pop, empty;
  logic [BeatW-1:0]      head;

  state_e         state_q, state_d;
  logic [IdxW-1:0] grant_q, grant_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [31:0]    pkt_count_q, pkt_count_d;
  logic [IdxW-1:0] cand;
  logic           found;

  // FIFO status: ready drops one entry early so an in-flight beat always fits.
  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      empty[i]         = (count_q[i] == '0);
      s_axis_tready[i] = (count_q[i] < CntW'(Depth - 1));
      wr_en[i]         = s_axis_tvalid[i] & s_axis_tready[i];
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge axi_aclk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (wr_en[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {s_axis_tdata[i*DataW +: DataW],
                                  s_axis_tstrb[i*StrbW +: StrbW],
                                  s_axis_tuser[i*UserW +: UserW],
                                  s_axis_tlast[i]};
      end
    end
  end

  // FIFO pointers and occupancy; a same-cycle write and pop leaves occupancy unchanged.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        if (pop[i])   rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        case ({wr_en[i], pop[i]})
          2'b10:   count_q[i] <= count_q[i] + CntW'(1);
          2'b01:   count_q[i] <= count_q[i] - CntW'(1);
          default: count_q[i] <= count_q[i];
        endcase
      end
    end
  end

  assign head          = mem_q[grant_q][rd_ptr_q[grant_q]];
  assign m_axis_tdata  = head[BeatW-1 -: DataW];
  assign m_axis_tstrb  = head[UserW+1 +: StrbW];
  assign m_axis_tuser  = head[1 +: UserW];
  assign m_axis_tlast  = head[0];
  assign grant_idx     = grant_q;
  assign pkt_count     = pkt_count_q;

  // Arbiter FSM: pick next non-empty input from rr_q in IDLE, stream it until tlast pops.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    pkt_count_d   = pkt_count_q;
    m_axis_tvalid = 1'b0;
    pop           = '0;
    cand          = '0;
    found         = 1'b0;
    unique case (state_q)
      StIdle: begin
        for (int k = 0; k < NUM_INPUTS; k++) begin
          cand = IdxW'((int'(rr_q) + k) % NUM_INPUTS);
          if (!found && !empty[cand]) begin
            grant_d = cand;
            found   = 1'b1;
          end
        end
        if (found) state_d = StXfer;
      end
      StXfer: begin
        m_axis_tvalid = !empty[grant_q];
        if (m_axis_tvalid && m_axis_tready) begin
          pop[grant_q] = 1'b1;
          if (m_axis_tlast) begin
            rr_d        = (grant_q == IdxW'(NUM_INPUTS - 1)) ? '0 : grant_q + IdxW'(1);
            pkt_count_d = pkt_count_q + 32'd1;
            state_d     = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_q        <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      pkt_count_q <= pkt_count_d;
    end
  end

endmodule

// File: tb/tb_filter_input_arbiter.sv
// Bench for filter_input_arbiter: directed scenarios plus randomized traffic, with a
// transaction-level model (per-input beat queues, round-robin packet grants) checked
// every cycle by a monitor process.
module tb_filter_input_arbiter;
  localparam int N     = 4;
  localparam int DW    = 256;
  localparam int SW    = DW / 8;
  localparam int UW    = 128;
  localparam int IW    = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  typedef struct packed {
    beat_t         b;
    logic [IW-1:0] g;
    int            cyc;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N*SW-1:0] s_tstrb = '0;
  logic [N*UW-1:0] s_tuser = '0;
  logic [N-1:0]    s_tvalid = '0;
  logic [N-1:0]    s_tready;
  logic [N-1:0]    s_tlast = '0;
  logic [DW-1:0]   m_tdata;
  logic [SW-1:0]   m_tstrb;
  logic [UW-1:0]   m_tuser;
  logic            m_tvalid;
  logic            m_tready = 1'b0;
  logic            m_tlast;
  logic [IW-1:0]   grant_idx;
  logic [31:0]     pkt_count;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t stim [N][$];
  beat_t mq   [N][$];
  rec_t  log_q[$];
  logic [N-1:0] hold = '0;
  int    mready_mode = 0;
  int    cyc = 0;
  bit    mbusy = 0;
  int    mgrant = 0;
  int    mrr = 0;
  logic [31:0] mcount = '0;
  int    load_seq = 0;
  int    load_seen = 0;
  logic [31:0] load_val = '0;

  always #5 clk = ~clk;

  filter_input_arbiter dut (
    .axi_aclk     (clk),
    .axi_aresetn  (rst_n),
    .s_axis_tdata (s_tdata),
    .s_axis_tstrb (s_tstrb),
    .s_axis_tuser (s_tuser),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tstrb (m_tstrb),
    .m_axis_tuser (m_tuser),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .grant_idx    (grant_idx),
    .pkt_count    (pkt_count)
  );

  function automatic beat_t mk_beat(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.s = SW'({$urandom, $urandom});
    b.u = {$urandom, $urandom, $urandom, $urandom};
    b.l = l;
    return b;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic bit pending();
    bit p = mbusy;
    for (int i = 0; i < N; i++) if (stim[i].size() > 0 || mq[i].size() > 0) p = 1;
    return p;
  endfunction

  // Reference model: checks every cycle at the falling edge.
  task automatic monitor();
    beat_t h, ob, ib;
    bit    expv;
    int    idx;
    forever begin
      @(negedge clk);
      cyc++;
      if (load_seq != load_seen) begin
        mcount    = load_val;
        load_seen = load_seq;
      end
      if (!rst_n) begin
        n_cmp++;
        if (m_tvalid !== 1'b0) begin
          n_bad++;
          $display("FAIL mon_rst_tvalid: got %b want 0", m_tvalid);
        end
        for (int i = 0; i < N; i++) mq[i].delete();
        mbusy  = 0;
        mrr    = 0;
        mcount = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          n_cmp++;
          if (s_tready[i] !== (mq[i].size() < DEPTH - 1)) begin
            n_bad++;
            $display("FAIL mon_s_tready[%0d]: got %b want %b (occ %0d)", i, s_tready[i],
                     mq[i].size() < DEPTH - 1, mq[i].size());
          end
        end
        n_cmp++;
        if (pkt_count !== mcount) begin
          n_bad++;
          $display("FAIL mon_pkt_count: got %0h want %0h", pkt_count, mcount);
        end
        if (!mbusy) begin
          n_cmp++;
          if (m_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL mon_idle_tvalid: got %b want 0 (cyc %0d)", m_tvalid, cyc);
          end
          for (int k = 0; k < N; k++) begin
            idx = (mrr + k) % N;
            if (!mbusy && mq[idx].size() > 0) begin
              mgrant = idx;
              mbusy  = 1;
            end
          end
        end else begin
          n_cmp++;
          if (grant_idx !== IW'(mgrant)) begin
            n_bad++;
            $display("FAIL mon_grant: got %0d want %0d", grant_idx, mgrant);
          end
          expv = mq[mgrant].size() > 0;
          n_cmp++;
          if (m_tvalid !== expv) begin
            n_bad++;
            $display("FAIL mon_xfer_tvalid: got %b want %b (cyc %0d)", m_tvalid, expv, cyc);
          end
          if (expv && m_tvalid) begin
            h  = mq[mgrant][0];
            ob = {m_tdata, m_tstrb, m_tuser, m_tlast};
            n_cmp++;
            if (ob !== h) begin
              n_bad++;
              $display("FAIL mon_beat: got %h want %h", ob, h);
            end
            if (m_tready) begin
              void'(mq[mgrant].pop_front());
              log_q.push_back('{b: ob, g: grant_idx, cyc: cyc});
              if (h.l) begin
                mrr    = (mgrant + 1) % N;
                mcount = mcount + 32'd1;
                mbusy  = 0;
              end
            end
          end
        end
        for (int i = 0; i < N; i++) begin
          if (s_tvalid[i] && s_tready[i]) begin
            ib = {s_tdata[i*DW +: DW], s_tstrb[i*SW +: SW], s_tuser[i*UW +: UW], s_tlast[i]};
            mq[i].push_back(ib);
          end
        end
      end
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int i = 0; i < N; i++) begin
      if (!hold[i] && stim[i].size() > 0) begin
        b = stim[i][0];
        s_tdata[i*DW +: DW] = b.d;
        s_tstrb[i*SW +: SW] = b.s;
        s_tuser[i*UW +: UW] = b.u;
        s_tlast[i]          = b.l;
        s_tvalid[i]         = 1'b1;
      end else begin
        s_tvalid[i] = 1'b0;
      end
    end
    if (mready_mode == 2) m_tready = 1'($urandom_range(0, 1));
    else m_tready = (mready_mode == 1);
  endtask

  // One clock: note accepted input beats, then present the next ones after the edge.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i] && stim[i].size() > 0) void'(stim[i].pop_front());
    drive();
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while (pending() && c < maxc) begin
      step();
      c++;
    end
    if (pending()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got pending traffic after %0d cycles want none", maxc);
    end
    repeat (2) step();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) stim[i].delete();
    hold        = '0;
    mready_mode = 1;
    s_tvalid    = '0;
    rst_n       = 1'b0;
    repeat (3) step();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
    n_cmp++;
    if (s_tready !== 4'hF) begin n_bad++; $display("FAIL rst_tready: got %h want f", s_tready); end
    n_cmp++;
    if (pkt_count !== 32'd0) begin n_bad++; $display("FAIL rst_cnt: got %0h want 0", pkt_count); end
    n_cmp++;
    if (grant_idx !== 2'd0) begin n_bad++; $display("FAIL rst_grant: got %0d want 0", grant_idx); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_d [3];
    int base;
    do_reset();
    exp_d[0] = DW'(8'h11);
    exp_d[1] = DW'(8'h22);
    exp_d[2] = DW'(8'h33);
    base = log_q.size();
    for (int k = 0; k < 3; k++) stim[2].push_back(mk_beat(exp_d[k], k == 2));
    drive();
    drain(50);
    n_cmp++;
    if (log_q.size() - base !== 3) begin
      n_bad++;
      $display("FAIL single_beats: got %0d want 3", log_q.size() - base);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (log_q[base+k].b.d !== exp_d[k] || log_q[base+k].g !== 2'd2
            || log_q[base+k].b.l !== (k == 2)) begin
          n_bad++;
          $display("FAIL single_beat%0d: got d=%0h g=%0d l=%b want d=%0h g=2 l=%b", k,
                   log_q[base+k].b.d, log_q[base+k].g, log_q[base+k].b.l, exp_d[k], k == 2);
        end
      end
      n_cmp++;
      if (log_q[base+2].cyc - log_q[base].cyc !== 2) begin
        n_bad++;
        $display("FAIL single_burst: got span %0d want 2", log_q[base+2].cyc - log_q[base].cyc);
      end
    end
    n_cmp++;
    if (pkt_count !== 32'd1 || grant_idx !== 2'd2 || m_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_end: got cnt=%0d g=%0d v=%b want 1 2 0", pkt_count, grant_idx,
               m_tvalid);
    end
  endtask

  task automatic test_round_robin();
    int base;
    do_reset();
    base = log_q.size();
    for (int p = 0; p < N; p++)
      for (int k = 0; k < 2; k++) stim[p].push_back(mk_beat(DW'(16 * p + k), k == 1));
    drive();
    drain(80);
    n_cmp++;
    if (log_q.size() - base !== 8) begin
      n_bad++;
      $display("FAIL rr_beats: got %0d want 8", log_q.size() - base);
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (log_q[base+k].g !== IW'(k / 2) || log_q[base+k].b.d !== DW'(16 * (k / 2) + k % 2)) begin
          n_bad++;
          $display("FAIL rr_order%0d: got g=%0d d=%0h want g=%0d d=%0h", k, log_q[base+k].g,
                   log_q[base+k].b.d, k / 2, 16 * (k / 2) + k % 2);
        end
      end
      n_cmp++;
      if (log_q[base+7].cyc - log_q[base].cyc !== 10) begin
        n_bad++;
        $display("FAIL rr_bubbles: got span %0d want 10", log_q[base+7].cyc - log_q[base].cyc);
      end
    end
    n_cmp++;
    if (pkt_count !== 32'd4) begin n_bad++; $display("FAIL rr_cnt: got %0d want 4", pkt_count); end
  endtask

  task automatic test_backpressure();
    int  base, c;
    bit  saw_full;
    do_reset();
    base = log_q.size();
    for (int k = 0; k < 6; k++) stim[0].push_back(mk_beat(DW'(8'hB0 + k), k == 5));
    drive();
    c = 0;
    while (log_q.size() - base < 2 && c < 40) begin step(); c++; end
    mready_mode = 0;
    m_tready    = 1'b0;
    saw_full    = 0;
    for (int t = 0; t < 5; t++) begin
      step();
      if (s_tready[0] === 1'b0) saw_full = 1;
      n_cmp++;
      if (m_tvalid !== 1'b1 || m_tdata !== DW'(8'hB2)) begin
        n_bad++;
        $display("FAIL bp_hold%0d: got v=%b d=%0h want v=1 d=b2", t, m_tvalid, m_tdata);
      end
    end
    n_cmp++;
    if (!saw_full) begin n_bad++; $display("FAIL bp_tready: got never low want low"); end
    mready_mode = 1;
    drive();
    drain(60);
    n_cmp++;
    if (log_q.size() - base !== 6) begin
      n_bad++;
      $display("FAIL bp_beats: got %0d want 6", log_q.size() - base);
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_cmp++;
        if (log_q[base+k].b.d !== DW'(8'hB0 + k)) begin
          n_bad++;
          $display("FAIL bp_order%0d: got %0h want %0h", k, log_q[base+k].b.d, 8'hB0 + k);
        end
      end
    end
  endtask

  task automatic test_no_interleave();
    int base;
    do_reset();
    base = log_q.size();
    stim[0].push_back(mk_beat(DW'(8'hA0), 1'b0));
    stim[1].push_back(mk_beat(DW'(8'hC0), 1'b0));
    stim[1].push_back(mk_beat(DW'(8'hC1), 1'b1));
    drive();
    repeat (6) step();
    n_cmp++;
    if (log_q.size() - base !== 1 || grant_idx !== 2'd0 || m_tvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL ni_stall: got beats=%0d g=%0d v=%b want 1 0 0", log_q.size() - base,
               grant_idx, m_tvalid);
    end
    stim[0].push_back(mk_beat(DW'(8'hA1), 1'b1));
    drive();
    drain(60);
    n_cmp++;
    if (log_q.size() - base !== 4) begin
      n_bad++;
      $display("FAIL ni_beats: got %0d want 4", log_q.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (log_q[base+k].g !== IW'(k / 2)) begin
          n_bad++;
          $display("FAIL ni_order%0d: got g=%0d want %0d", k, log_q[base+k].g, k / 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int base, c;
    do_reset();
    stim[2].push_back(mk_beat(DW'(8'h5A), 1'b1));
    drive();
    drain(30);
    base = log_q.size();
    for (int k = 0; k < 4; k++) stim[1].push_back(mk_beat(DW'(8'h70 + k), k == 3));
    drive();
    c = 0;
    while (log_q.size() - base < 1 && c < 40) begin step(); c++; end
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata !== DW'(8'h71)) begin
      n_bad++;
      $display("FAIL rm_pre: got v=%b d=%0h want v=1 d=71", m_tvalid, m_tdata);
    end
    #1;
    for (int i = 0; i < N; i++) stim[i].delete();
    s_tvalid = '0;
    rst_n    = 1'b0;
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0 || pkt_count !== 32'd0) begin
      n_bad++;
      $display("FAIL rm_async: got v=%b cnt=%0d want 0 0", m_tvalid, pkt_count);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    base = log_q.size();
    for (int k = 0; k < 4; k++) stim[3].push_back(mk_beat(DW'(8'hE0 + k), k == 3));
    drive();
    drain(60);
    n_cmp++;
    if (log_q.size() - base !== 4) begin
      n_bad++;
      $display("FAIL rm_beats: got %0d want 4", log_q.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (log_q[base+k].g !== 2'd3 || log_q[base+k].b.d !== DW'(8'hE0 + k)) begin
          n_bad++;
          $display("FAIL rm_fresh%0d: got g=%0d d=%0h want g=3 d=%0h", k, log_q[base+k].g,
                   log_q[base+k].b.d, 8'hE0 + k);
        end
      end
    end
    n_cmp++;
    if (pkt_count !== 32'd1) begin n_bad++; $display("FAIL rm_cnt: got %0d want 1", pkt_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    @(posedge clk);
    #2;
    force dut.pkt_count_q = 32'hFFFF_FFFF;
    load_val = 32'hFFFF_FFFF;
    load_seq++;
    @(posedge clk);
    #2;
    release dut.pkt_count_q;
    n_cmp++;
    if (pkt_count !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL wrap_load: got %0h want ffffffff", pkt_count);
    end
    stim[1].push_back(mk_beat(DW'(8'h99), 1'b1));
    drive();
    drain(30);
    n_cmp++;
    if (pkt_count !== 32'd0) begin n_bad++; $display("FAIL wrap: got %0h want 0", pkt_count); end
  endtask

  task automatic test_random();
    int base, beats, pkts, len, c;
    do_reset();
    base  = log_q.size();
    beats = 0;
    pkts  = 0;
    for (int i = 0; i < N; i++) begin
      for (int p = 0; p < $urandom_range(1, 4); p++) begin
        len = $urandom_range(1, 5);
        for (int k = 0; k < len; k++) stim[i].push_back(mk_beat(rand_data(), k == len - 1));
        beats += len;
        pkts++;
      end
    end
    mready_mode = 2;
    drive();
    c = 0;
    while (pending() && c < 300) begin
      hold = N'($urandom) & N'($urandom);
      step();
      c++;
    end
    hold        = '0;
    mready_mode = 1;
    drive();
    drain(300);
    n_cmp++;
    if (log_q.size() - base !== beats || pkt_count !== 32'(pkts)) begin
      n_bad++;
      $display("FAIL rand_totals: got beats=%0d pkts=%0d want %0d %0d", log_q.size() - base,
               pkt_count, beats, pkts);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_no_interleave();
    test_reset_mid();
    test_wrap();
    for (int r = 0; r < 4; r++) test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500000 want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/filter_input_arbiter.md
Name: filter_input_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single filter datapath between NUM_INPUTS upstream AXI-Stream ports (e.g. 4 MAC ports).
- Buffers each input in a small fallthrough FIFO and grants one input per packet.
- Forwards the granted input's beats unchanged (tdata/tstrb/tuser/tlast) to the filter's slave stream port.
- Sits between the port input queues and the filter in the user datapath.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, output tdata width.
- C_S_AXIS_DATA_WIDTH, 256, per-input tdata width; must equal C_M_AXIS_DATA_WIDTH.
- C_M_AXIS_TUSER_WIDTH, 128, output tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, per-input tuser width; must equal C_M_AXIS_TUSER_WIDTH.
- NUM_INPUTS, 4, number of requesting streams (2..8).
- FIFO_DEPTH_BITS, 2, log2 depth of each per-input FIFO.

Ports:
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  NUM_INPUTS*C_S_AXIS_DATA_WIDTH  input i occupies slice [i*W +: W].
- s_axis_tstrb  in  NUM_INPUTS*C_S_AXIS_DATA_WIDTH/8  per-input strobes, same slicing.
- s_axis_tuser  in  NUM_INPUTS*C_S_AXIS_TUSER_WIDTH  per-input tuser.
- s_axis_tvalid  in  NUM_INPUTS  per-input valid.
- s_axis_tready  out  NUM_INPUTS  per-input ready = !fifo_nearly_full[i].
- s_axis_tlast  in  NUM_INPUTS  per-input last.
- m_axis_tdata  out  C_M_AXIS_DATA_WIDTH  granted FIFO head data.
- m_axis_tstrb  out  C_M_AXIS_DATA_WIDTH/8  granted head strobes.
- m_axis_tuser  out  C_M_AXIS_TUSER_WIDTH  granted head tuser.
- m_axis_tvalid  out  1  high in XFER when granted FIFO is non-empty.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  granted head last.
- grant_idx  out  log2(NUM_INPUTS)  currently or last granted input.
- pkt_count  out  32  packets forwarded; wraps 0xFFFFFFFF->0.

Behaviour:
- Reset (axi_aresetn=0, async): all FIFOs empty; state=IDLE; rr_ptr=0; grant_idx=0; pkt_count=0; m_axis_tvalid=0; s_axis_tready=all 1s after the FIFOs clear.
- FIFO write: FIFO i is written when s_axis_tvalid[i] & s_axis_tready[i]. Beat-to-head latency is 1 cycle.
- State IDLE:
  - If any FIFO is non-empty, select the first non-empty index searching rr_ptr, rr_ptr+1, ... mod NUM_INPUTS.
  - Register that index into grant_idx and move to XFER.
  - Otherwise stay in IDLE.
  - m_axis_tvalid=0 throughout IDLE.
- State XFER:
  - Outputs are driven from FIFO[grant_idx] head.
  - m_axis_tvalid = !empty[grant_idx].
  - FIFO pop = m_axis_tvalid & m_axis_tready.
  - Empty FIFO mid-packet: hold grant; tvalid=0; wait. Other inputs are never interleaved mid-packet.
  - On a pop with tlast=1: rr_ptr <= (grant_idx+1) mod NUM_INPUTS; pkt_count++; next state IDLE.
- Inter-packet timing: one idle bubble cycle between packets (IDLE selection cycle).
- Output stability: m_axis_* are stable while tvalid=1 and tready=0 (FIFO head is not popped).
- Simultaneous write and pop on the same FIFO is legal; FIFO occupancy is unchanged.
- Single-beat packet (tlast on first beat): occupies XFER for one accepted beat, then returns to IDLE.
- Only one input active: that input is re-granted every packet. Throughput is 1 beat/cycle within a packet.
- Fairness: with all inputs backlogged, grants cycle 0,1,...,N-1,0.
- Reset mid-packet: the partial packet is discarded. Downstream may observe a truncated packet; it must reset from the same axi_aresetn.
- tuser content is not interpreted; it is passed through verbatim.

Test Plan:
- Reset, then single input: input 2 sends a 3-beat packet (tdata=0x11,0x22,0x33; tlast on beat 3), m_axis_tready=1 -> output shows the same 3 beats in order; grant_idx=2; pkt_count=1; tvalid low before the first beat and after the last.
- Round-robin: all 4 inputs preloaded with one 2-beat packet each, tready=1 -> packets emerge in order 0,1,2,3; exactly one tvalid=0 cycle between packets; pkt_count=4.
- Backpressure: tready=0 for 5 cycles mid-packet -> output beat held constant; s_axis_tready[i] drops when the FIFO is nearly full; no beat lost or duplicated once tready returns to 1.
- No interleave: input 0 sends beat 1, stalls 4 cycles, then sends its tlast beat, while input 1 has a packet waiting -> input 1 data appears only after input 0's tlast is accepted.
- Reset mid-packet: assert axi_aresetn=0 during beat 2 of a 4-beat packet -> m_axis_tvalid=0 immediately; pkt_count=0; after release, a fresh packet on input 3 is granted first (rr_ptr=0 search) and forwards intact.
- Counter wrap: force pkt_count to 0xFFFFFFFF, send one packet -> pkt_count=0.
